// File: rtl/i2c_request_arbiter.sv
// rtl/i2c_request_arbiter.sv - round-robin arbiter sharing one I2C write controller between two requesters
module i2c_request_arbiter #(
   parameter logic [6:0] DEV_ADDR      = 7'h40,
   parameter int         TIMEOUT_TICKS = 4096
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req0_i,
   input  logic [7:0] reg0_i,
   input  logic [7:0] data0_i,
   output logic       gnt0_o,
   output logic       done0_o,
   input  logic       req1_i,
   input  logic [7:0] reg1_i,
   input  logic [7:0] data1_i,
   output logic       gnt1_o,
   output logic       done1_o,
   output logic [6:0] ctl_address_o,
   output logic       ctl_rw_o,
   output logic [7:0] ctl_register_o,
   output logic [7:0] ctl_data_o,
   output logic       ctl_execute_o,
   input  logic       ctl_busy_i,
   output logic       timeout_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_DONE,
      S_COMPLETE
   } state_t;

   // Counter value at which the watchdog gives up; completion then lands
   // TIMEOUT_TICKS cycles after the execute pulse.
   localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_TICKS - 1);

   state_t      r_state;
   logic        r_owner;
   logic        r_last;
   logic [15:0] r_wd;
   logic        r_gnt0;
   logic        r_gnt1;
   logic        r_done0;
   logic        r_done1;
   logic        r_exec;
   logic        r_timeout;
   logic        r_busy;
   logic [7:0]  r_reg;
   logic [7:0]  r_data;

   logic        w_any_req;
   logic        w_pick;
   logic [15:0] w_wd_next;
   logic        w_wd_expire;

   assign w_any_req   = req0_i | req1_i;
   // On a tie the requester that did not win last time goes next.
   assign w_pick      = (req0_i & req1_i) ? ~r_last : req1_i;
   assign w_wd_next   = r_wd + 16'd1;
   assign w_wd_expire = (w_wd_next == LP_WD_LAST);

   // Arbitration FSM with registered handshake, payload and watchdog.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
         r_wd      <= 16'd0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_exec    <= 1'b0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
         r_reg     <= 8'h00;
         r_data    <= 8'h00;
      end else begin
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
         r_exec    <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!ctl_busy_i && w_any_req) begin
                  r_owner <= w_pick;
                  r_last  <= w_pick;
                  r_reg   <= w_pick ? reg1_i : reg0_i;
                  r_data  <= w_pick ? data1_i : data0_i;
                  r_gnt0  <= ~w_pick;
                  r_gnt1  <= w_pick;
                  r_exec  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_wd    <= 16'd0;
               r_state <= S_WAIT_START;
            end
            S_WAIT_START, S_WAIT_DONE: begin
               r_wd <= w_wd_next;
               // Watchdog is evaluated first so it wins a tie with busy.
               if (w_wd_expire) begin
                  r_done0   <= ~r_owner;
                  r_done1   <= r_owner;
                  r_timeout <= 1'b1;
                  r_state   <= S_COMPLETE;
               end else if (r_state == S_WAIT_START) begin
                  if (ctl_busy_i) begin
                     r_state <= S_WAIT_DONE;
                  end
               end else if (!ctl_busy_i) begin
                  r_done0 <= ~r_owner;
                  r_done1 <= r_owner;
                  r_state <= S_COMPLETE;
               end
            end
            S_COMPLETE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0_o         = r_gnt0;
   assign gnt1_o         = r_gnt1;
   assign done0_o        = r_done0;
   assign done1_o        = r_done1;
   assign ctl_address_o  = DEV_ADDR;
   assign ctl_rw_o       = 1'b0;
   assign ctl_register_o = r_reg;
   assign ctl_data_o     = r_data;
   assign ctl_execute_o  = r_exec;
   assign timeout_o      = r_timeout;
   assign busy_o         = r_busy;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// tb/tb_i2c_request_arbiter.sv - self-checking bench for i2c_request_arbiter
module tb_i2c_request_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       req0, req1;
   logic [7:0] reg0, data0, reg1, data1;
   logic       busy_a, busy_b;

   logic       a_gnt0, a_gnt1, a_done0, a_done1, a_rw, a_exec, a_to, a_busy;
   logic [6:0] a_addr;
   logic [7:0] a_reg, a_data;
   logic       b_gnt0, b_gnt1, b_done0, b_done1, b_rw, b_exec, b_to, b_busy;
   logic [6:0] b_addr;
   logic [7:0] b_reg, b_data;

   int n_cmp = 0;
   int n_bad = 0;
   int last_owner;

   // Default watchdog: normal transactions.
   i2c_request_arbiter #(.DEV_ADDR(7'h40), .TIMEOUT_TICKS(4096)) u_a (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_i(req0), .reg0_i(reg0), .data0_i(data0), .gnt0_o(a_gnt0), .done0_o(a_done0),
      .req1_i(req1), .reg1_i(reg1), .data1_i(data1), .gnt1_o(a_gnt1), .done1_o(a_done1),
      .ctl_address_o(a_addr), .ctl_rw_o(a_rw), .ctl_register_o(a_reg), .ctl_data_o(a_data),
      .ctl_execute_o(a_exec), .ctl_busy_i(busy_a), .timeout_o(a_to), .busy_o(a_busy)
   );

   // Short watchdog: timeout scenarios.
   i2c_request_arbiter #(.DEV_ADDR(7'h40), .TIMEOUT_TICKS(16)) u_b (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_i(req0), .reg0_i(reg0), .data0_i(data0), .gnt0_o(b_gnt0), .done0_o(b_done0),
      .req1_i(req1), .reg1_i(reg1), .data1_i(data1), .gnt1_o(b_gnt1), .done1_o(b_done1),
      .ctl_address_o(b_addr), .ctl_rw_o(b_rw), .ctl_register_o(b_reg), .ctl_data_o(b_data),
      .ctl_execute_o(b_exec), .ctl_busy_i(busy_b), .timeout_o(b_to), .busy_o(b_busy)
   );

   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; busy_a = 1'b0; busy_b = 1'b0;
      reg0 = 8'h00; data0 = 8'h00; reg1 = 8'h00; data1 = 8'h00;
      nclk(); nclk();
      rst_n = 1'b1;
      last_owner = 1;
   endtask

   task automatic test_reset();
      do_reset();
      reg0 = 8'h5A; data0 = 8'hC3; req0 = 1'b1;
      nclk();
      n_cmp++; if (a_gnt0 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_gnt: got %b expected 1", a_gnt0); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({a_gnt0,a_gnt1,a_done0,a_done1,a_exec,a_to,a_busy} !== 7'b0) begin n_bad++; $display("FAIL rst_flags_a: got %b expected 0000000", {a_gnt0,a_gnt1,a_done0,a_done1,a_exec,a_to,a_busy}); end
      n_cmp++; if ({b_gnt0,b_gnt1,b_done0,b_done1,b_exec,b_to,b_busy} !== 7'b0) begin n_bad++; $display("FAIL rst_flags_b: got %b expected 0000000", {b_gnt0,b_gnt1,b_done0,b_done1,b_exec,b_to,b_busy}); end
      n_cmp++; if ({a_reg,a_data} !== 16'h0000) begin n_bad++; $display("FAIL rst_payload: got %h expected 0000", {a_reg,a_data}); end
      n_cmp++; if ({a_addr,a_rw} !== {7'h40,1'b0}) begin n_bad++; $display("FAIL rst_addr_rw: got %h expected %h", {a_addr,a_rw}, {7'h40,1'b0}); end
      req0 = 1'b0;
      nclk();
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      bit seen1;
      seen1 = 1'b0;
      do_reset();
      reg0 = 8'h00; data0 = 8'h21; req0 = 1'b1;
      nclk();
      n_cmp++; if ({a_gnt0,a_exec,a_gnt1} !== 3'b110) begin n_bad++; $display("FAIL sw_grant: got %b expected 110", {a_gnt0,a_exec,a_gnt1}); end
      n_cmp++; if ({a_addr,a_rw,a_reg,a_data} !== {7'h40,1'b0,8'h00,8'h21}) begin n_bad++; $display("FAIL sw_ctl: got %h expected %h", {a_addr,a_rw,a_reg,a_data}, {7'h40,1'b0,8'h00,8'h21}); end
      req0 = 1'b0; busy_a = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         nclk();
         seen1 |= a_gnt1 | a_done1;
         n_cmp++; if ({a_gnt0,a_exec,a_done0,a_to} !== 4'b0) begin n_bad++; $display("FAIL sw_quiet cycle %0d: got %b expected 0000", i, {a_gnt0,a_exec,a_done0,a_to}); end
         if (i == 40) busy_a = 1'b0;
      end
      nclk();
      seen1 |= a_gnt1 | a_done1;
      n_cmp++; if ({a_done0,a_to} !== 2'b10) begin n_bad++; $display("FAIL sw_done: got %b expected 10", {a_done0,a_to}); end
      nclk();
      seen1 |= a_gnt1 | a_done1;
      n_cmp++; if ({a_done0,a_busy} !== 2'b00) begin n_bad++; $display("FAIL sw_idle: got %b expected 00", {a_done0,a_busy}); end
      n_cmp++; if (seen1 !== 1'b0) begin n_bad++; $display("FAIL sw_req1_quiet: got %b expected 0", seen1); end
   endtask

   task automatic test_contention();
      int exp_o, k, len;
      bit got;
      do_reset();
      reg0 = 8'($urandom); data0 = 8'($urandom); reg1 = 8'($urandom); data1 = 8'($urandom);
      req0 = 1'b1; req1 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_o = (last_owner == 1) ? 0 : 1;
         got = 1'b0;
         for (k = 0; k < 8; k++) begin
            nclk();
            if (a_gnt0 | a_gnt1) begin got = 1'b1; break; end
         end
         n_cmp++;
         if (!got) begin
            n_bad++; $display("FAIL cont_grant_wait txn %0d: got no grant expected grant %0d", t, exp_o);
         end else begin
            n_cmp++; if ({a_gnt1,a_gnt0} !== ((exp_o == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL cont_order txn %0d: got %b expected owner %0d", t, {a_gnt1,a_gnt0}, exp_o); end
            n_cmp++; if ({a_reg,a_data} !== ((exp_o == 1) ? {reg1,data1} : {reg0,data0})) begin n_bad++; $display("FAIL cont_payload txn %0d: got %h expected %h", t, {a_reg,a_data}, (exp_o == 1) ? {reg1,data1} : {reg0,data0}); end
            n_cmp++; if (k !== ((t == 0) ? 0 : 1)) begin n_bad++; $display("FAIL cont_latency txn %0d: got %0d expected %0d", t, k, (t == 0) ? 0 : 1); end
         end
         last_owner = exp_o;
         if (exp_o == 0) begin reg0 = 8'($urandom); data0 = 8'($urandom); end
         else begin reg1 = 8'($urandom); data1 = 8'($urandom); end
         busy_a = 1'b1;
         len = $urandom_range(2, 8);
         repeat (len) nclk();
         busy_a = 1'b0;
         nclk();
         n_cmp++; if ({a_done1,a_done0} !== ((exp_o == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL cont_done txn %0d: got %b expected owner %0d", t, {a_done1,a_done0}, exp_o); end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_payload_latch();
      logic [7:0] sr, sd;
      int len;
      bit got;
      do_reset();
      sr = 8'($urandom); sd = 8'($urandom);
      reg0 = sr; data0 = sd; req0 = 1'b1;
      nclk();
      n_cmp++; if (a_gnt0 !== 1'b1) begin n_bad++; $display("FAIL pl_grant: got %b expected 1", a_gnt0); end
      req0 = 1'b0; busy_a = 1'b1;
      len = $urandom_range(4, 12);
      nclk();
      reg0 = ~sr; data0 = ~sd;
      got = 1'b0;
      for (int k = 1; k < len + 6; k++) begin
         if (k == len) busy_a = 1'b0;
         nclk();
         n_cmp++; if ({a_reg,a_data} !== {sr,sd}) begin n_bad++; $display("FAIL pl_hold cycle %0d: got %h expected %h", k, {a_reg,a_data}, {sr,sd}); end
         if (a_done0) begin got = 1'b1; break; end
      end
      n_cmp++; if (!got) begin n_bad++; $display("FAIL pl_done_wait: got no done0 expected done0"); end
   endtask

   task automatic test_random();
      bit pend0, pend1, got;
      int exp_o, len;
      do_reset();
      pend0 = 1'b0; pend1 = 1'b0;
      for (int it = 0; it < 12; it++) begin
         if (!pend0 && $urandom_range(0, 1) == 1) begin pend0 = 1'b1; reg0 = 8'($urandom); data0 = 8'($urandom); req0 = 1'b1; end
         if (!pend1 && $urandom_range(0, 1) == 1) begin pend1 = 1'b1; reg1 = 8'($urandom); data1 = 8'($urandom); req1 = 1'b1; end
         if (!pend0 && !pend1) begin pend0 = 1'b1; reg0 = 8'($urandom); data0 = 8'($urandom); req0 = 1'b1; end
         exp_o = (pend0 && pend1) ? ((last_owner == 1) ? 0 : 1) : (pend1 ? 1 : 0);
         got = 1'b0;
         for (int k = 0; k < 8; k++) begin
            nclk();
            if (a_gnt0 | a_gnt1) begin got = 1'b1; break; end
         end
         n_cmp++;
         if (!got) begin
            n_bad++; $display("FAIL rnd_grant_wait iter %0d: got no grant expected owner %0d", it, exp_o);
         end else begin
            n_cmp++; if ({a_gnt1,a_gnt0,a_exec} !== ((exp_o == 1) ? 3'b101 : 3'b011)) begin n_bad++; $display("FAIL rnd_owner iter %0d: got %b expected owner %0d", it, {a_gnt1,a_gnt0,a_exec}, exp_o); end
            n_cmp++; if ({a_reg,a_data} !== ((exp_o == 1) ? {reg1,data1} : {reg0,data0})) begin n_bad++; $display("FAIL rnd_payload iter %0d: got %h expected %h", it, {a_reg,a_data}, (exp_o == 1) ? {reg1,data1} : {reg0,data0}); end
         end
         last_owner = exp_o;
         if (exp_o == 0) begin pend0 = 1'b0; req0 = 1'b0; end
         else begin pend1 = 1'b0; req1 = 1'b0; end
         busy_a = 1'b1;
         len = $urandom_range(2, 6);
         repeat (len) nclk();
         busy_a = 1'b0;
         nclk();
         n_cmp++; if ({a_done1,a_done0,a_to} !== ((exp_o == 1) ? 3'b100 : 3'b010)) begin n_bad++; $display("FAIL rnd_done iter %0d: got %b expected owner %0d", it, {a_done1,a_done0,a_to}, exp_o); end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset_midop();
      logic [7:0] nr, nd;
      do_reset();
      reg0 = 8'($urandom); data0 = 8'($urandom); req0 = 1'b1;
      nclk();
      n_cmp++; if (a_gnt0 !== 1'b1) begin n_bad++; $display("FAIL rm_first_grant: got %b expected 1", a_gnt0); end
      busy_a = 1'b1;
      nclk(); nclk(); nclk();
      n_cmp++; if ({a_busy,a_done0} !== 2'b10) begin n_bad++; $display("FAIL rm_inflight: got %b expected 10", {a_busy,a_done0}); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({a_gnt0,a_gnt1,a_done0,a_done1,a_exec,a_to,a_busy,a_reg,a_data} !== 23'h0) begin n_bad++; $display("FAIL rm_async_clear: got %h expected 000000", {a_gnt0,a_gnt1,a_done0,a_done1,a_exec,a_to,a_busy,a_reg,a_data}); end
      nr = 8'($urandom); nd = 8'($urandom);
      reg0 = nr; data0 = nd; busy_a = 1'b0;
      nclk();
      rst_n = 1'b1;
      nclk();
      n_cmp++; if ({a_gnt0,a_exec,a_done0,a_done1} !== 4'b1100) begin n_bad++; $display("FAIL rm_regrant: got %b expected 1100", {a_gnt0,a_exec,a_done0,a_done1}); end
      n_cmp++; if ({a_reg,a_data} !== {nr,nd}) begin n_bad++; $display("FAIL rm_payload: got %h expected %h", {a_reg,a_data}, {nr,nd}); end
      req0 = 1'b0; busy_a = 1'b1;
      repeat (3) nclk();
      busy_a = 1'b0;
      nclk();
      n_cmp++; if ({a_done0,a_to} !== 2'b10) begin n_bad++; $display("FAIL rm_done: got %b expected 10", {a_done0,a_to}); end
   endtask

   task automatic test_watchdog_no_busy();
      int k;
      bit got;
      do_reset();
      reg0 = 8'($urandom); data0 = 8'($urandom); req0 = 1'b1;
      nclk();
      n_cmp++; if ({b_gnt0,b_exec} !== 2'b11) begin n_bad++; $display("FAIL wn_grant: got %b expected 11", {b_gnt0,b_exec}); end
      req0 = 1'b0;
      got = 1'b0;
      for (k = 1; k <= 24; k++) begin
         nclk();
         if (b_done0 | b_done1 | b_to) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got) begin
         n_bad++; $display("FAIL wn_wait: got no done expected done0 with timeout");
      end else begin
         n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL wn_latency: got %0d expected 16", k); end
         n_cmp++; if ({b_done0,b_to,b_done1} !== 3'b110) begin n_bad++; $display("FAIL wn_flags: got %b expected 110", {b_done0,b_to,b_done1}); end
      end
      nclk();
      n_cmp++; if ({b_busy,b_done0,b_to} !== 3'b000) begin n_bad++; $display("FAIL wn_idle: got %b expected 000", {b_busy,b_done0,b_to}); end
   endtask

   task automatic test_watchdog_stuck();
      int k;
      bit got;
      do_reset();
      reg1 = 8'($urandom); data1 = 8'($urandom); req1 = 1'b1;
      nclk();
      n_cmp++; if ({b_gnt1,b_exec} !== 2'b11) begin n_bad++; $display("FAIL ws_grant: got %b expected 11", {b_gnt1,b_exec}); end
      req1 = 1'b0; busy_b = 1'b1;
      got = 1'b0;
      for (k = 1; k <= 24; k++) begin
         nclk();
         if (b_done0 | b_done1 | b_to) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got) begin
         n_bad++; $display("FAIL ws_wait: got no done expected done1 with timeout");
      end else begin
         n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL ws_latency: got %0d expected 16", k); end
         n_cmp++; if ({b_done1,b_to,b_done0} !== 3'b110) begin n_bad++; $display("FAIL ws_flags: got %b expected 110", {b_done1,b_to,b_done0}); end
      end
      reg0 = 8'($urandom); data0 = 8'($urandom); req0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         nclk();
         n_cmp++; if ({b_gnt0,b_gnt1} !== 2'b00) begin n_bad++; $display("FAIL ws_hold cycle %0d: got %b expected 00", i, {b_gnt0,b_gnt1}); end
      end
      busy_b = 1'b0;
      nclk();
      n_cmp++; if ({b_gnt0,b_exec} !== 2'b11) begin n_bad++; $display("FAIL ws_resume: got %b expected 11", {b_gnt0,b_exec}); end
      n_cmp++; if ({b_reg,b_data} !== {reg0,data0}) begin n_bad++; $display("FAIL ws_payload: got %h expected %h", {b_reg,b_data}, {reg0,data0}); end
      req0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_payload_latch();
      test_random();
      test_reset_midop();
      test_watchdog_no_busy();
      test_watchdog_stuck();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got still running expected finished");
      $fatal(1);
   end

endmodule
